// File: rtl/mesh_router_xy_if.sv
// -----------------------------------------------------------------------------
// mesh_router_xy_if
// Flit handshake bundle for the 5-port XY mesh router. Port p occupies
// bits [p*DATA_W +: DATA_W] of the flit buses and bit p of the strobes
// (0=Local, 1=North, 2=East, 3=South, 4=West).
//
// Signals:
//   in_valid  [5]         upstream flit valid, one bit per input port
//   in_ready  [5]         router accepts the flit on that input
//   in_flit   [5*DATA_W]  flits presented on the inputs
//   out_valid [5]         router flit valid, one bit per output port
//   out_ready [5]         downstream accepts the flit on that output
//   out_flit  [5*DATA_W]  flits presented on the outputs
//
// Modports:
//   slave  - the router side
//   master - the neighbour / traffic-source side
// -----------------------------------------------------------------------------
interface mesh_router_xy_if #(
    parameter int DATA_W = 16
) ();

    logic [4:0]          in_valid;
    logic [4:0]          in_ready;
    logic [5*DATA_W-1:0] in_flit;
    logic [4:0]          out_valid;
    logic [4:0]          out_ready;
    logic [5*DATA_W-1:0] out_flit;

    modport slave (
        input  in_valid,
        input  in_flit,
        output in_ready,
        output out_valid,
        output out_flit,
        input  out_ready
    );

    modport master (
        output in_valid,
        output in_flit,
        input  in_ready,
        input  out_valid,
        input  out_flit,
        output out_ready
    );

endinterface

// File: rtl/mesh_router_xy.sv
// -----------------------------------------------------------------------------
// mesh_router_xy
// Registered 5-port 2D-mesh router for single-flit packets. Each input has a
// FIFO; the FIFO head is routed with XY dimension-order routing against the
// router's own coordinates, and each output has a round-robin arbiter feeding
// a single registered output slot with valid/ready handshake.
//
// Flit layout: dest_x = flit[COORD_W-1:0], dest_y = flit[2*COORD_W-1:COORD_W],
// upper bits are payload and pass through unchanged.
//
// Ports:
//   clk         rising-edge clock
//   rst         synchronous reset, active-high
//   my_x, my_y  router coordinates (quasi-static)
//   bus         mesh_router_xy_if.slave: in_valid/in_ready/in_flit,
//               out_valid/out_ready/out_flit, port p = 0..4 (L,N,E,S,W)
//   stat_clr    clear delivery counters        (ROUTER_STATS_EN only)
//   stat_count  5 x 16-bit saturating delivered-flit counters, port p at
//               [p*16 +: 16]                   (ROUTER_STATS_EN only)
//
// Configuration: define ROUTER_STATS_EN to add the delivery counters and the
// stat_clr / stat_count ports. Routing and timing are identical either way.
// -----------------------------------------------------------------------------
module mesh_router_xy #(
    parameter int DATA_W     = 16,
    parameter int COORD_W    = 4,
    parameter int FIFO_DEPTH = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [COORD_W-1:0] my_x,
    input  logic [COORD_W-1:0] my_y,
    mesh_router_xy_if.slave    bus
`ifdef ROUTER_STATS_EN
    ,
    input  logic               stat_clr,
    output logic [5*16-1:0]    stat_count
`endif
);

    localparam int NP    = 5;
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    typedef enum logic [2:0] {
        PORT_LOCAL = 3'd0,
        PORT_NORTH = 3'd1,
        PORT_EAST  = 3'd2,
        PORT_SOUTH = 3'd3,
        PORT_WEST  = 3'd4
    } port_e;

    // XY dimension-order routing: resolve X first, then Y, else deliver locally.
    function automatic port_e xy_route(input logic [DATA_W-1:0]  flit,
                                       input logic [COORD_W-1:0] x,
                                       input logic [COORD_W-1:0] y);
        logic [COORD_W-1:0] dx;
        logic [COORD_W-1:0] dy;
        dx = flit[COORD_W-1:0];
        dy = flit[2*COORD_W-1:COORD_W];
        if (dx > x)      return PORT_EAST;
        else if (dx < x) return PORT_WEST;
        else if (dy > y) return PORT_NORTH;
        else if (dy < y) return PORT_SOUTH;
        else             return PORT_LOCAL;
    endfunction

    function automatic logic [2:0] next_port(input logic [2:0] p);
        return (p == 3'd4) ? 3'd0 : p + 3'd1;
    endfunction

    // Input FIFOs
    logic [DATA_W-1:0] fifo_mem [NP][FIFO_DEPTH];
    logic [PTR_W-1:0]  wr_ptr   [NP];
    logic [PTR_W-1:0]  rd_ptr   [NP];
    logic [CNT_W-1:0]  count    [NP];

    // Output slots and arbiters
    logic [2:0]        rr_ptr     [NP];
    logic [NP-1:0]     out_valid_q;
    logic [DATA_W-1:0] out_flit_q [NP];

    logic [DATA_W-1:0] head     [NP];
    port_e             head_dst [NP];
    logic [NP-1:0]     not_empty;
    logic [NP-1:0]     full;
    logic [NP-1:0]     push;
    logic [NP-1:0]     pop;
    logic [NP-1:0]     out_free;
    logic [NP-1:0]     gnt_valid;
    logic [2:0]        gnt_idx  [NP];

    for (genvar g = 0; g < NP; g++) begin : g_port
        assign head[g]      = fifo_mem[g][rd_ptr[g]];
        assign head_dst[g]  = xy_route(head[g], my_x, my_y);
        assign not_empty[g] = (count[g] != '0);
        assign full[g]      = (count[g] == CNT_W'(FIFO_DEPTH));
        // Ready comes from the registered count only, so a pop at full does
        // not reopen the input until the following cycle.
        assign bus.in_ready[g] = !rst && !full[g];
        assign push[g]         = bus.in_valid[g] && bus.in_ready[g];
        // An output slot can take a new flit if it is empty or is being
        // drained this cycle, giving one flit per cycle per port.
        assign out_free[g]     = !out_valid_q[g] || bus.out_ready[g];
        assign bus.out_valid[g]                   = out_valid_q[g];
        assign bus.out_flit[g*DATA_W +: DATA_W]   = out_flit_q[g];
    end

    // Per-output round-robin: first requesting input at or after rr_ptr.
    // NOTE: every variable written here gets a default before any condition,
    // otherwise a path that skips the assignment infers a latch.
    always_comb begin
        logic [2:0] idx;
        idx = 3'd0;
        for (int o = 0; o < NP; o++) begin
            gnt_valid[o] = 1'b0;
            gnt_idx[o]   = 3'd0;
            idx          = rr_ptr[o];
            for (int k = 0; k < NP; k++) begin
                if (out_free[o] && !gnt_valid[o] && not_empty[idx] &&
                    (head_dst[idx] == port_e'(o))) begin
                    gnt_valid[o] = 1'b1;
                    gnt_idx[o]   = idx;
                end
                idx = next_port(idx);
            end
        end
    end

    // A head routes to exactly one output, so at most one grant targets
    // any given input and the OR below never merges two pops.
    always_comb begin
        pop = '0;
        for (int o = 0; o < NP; o++) begin
            if (gnt_valid[o]) pop[gnt_idx[o]] = 1'b1;
        end
    end

    // NOTE: state registers use non-blocking assignments so every register
    // samples the pre-edge values, regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_q <= '0;
            for (int p = 0; p < NP; p++) begin
                wr_ptr[p]     <= '0;
                rd_ptr[p]     <= '0;
                count[p]      <= '0;
                rr_ptr[p]     <= 3'd0;
                out_flit_q[p] <= '0;
            end
        end else begin
            for (int p = 0; p < NP; p++) begin
                if (push[p]) wr_ptr[p] <= wr_ptr[p] + 1'b1;
                if (pop[p])  rd_ptr[p] <= rd_ptr[p] + 1'b1;
                count[p] <= count[p] + CNT_W'(push[p]) - CNT_W'(pop[p]);

                if (gnt_valid[p]) begin
                    out_valid_q[p] <= 1'b1;
                    out_flit_q[p]  <= head[gnt_idx[p]];
                    rr_ptr[p]      <= next_port(gnt_idx[p]);
                end else if (bus.out_ready[p]) begin
                    out_valid_q[p] <= 1'b0;
                end
            end
        end
    end

    // NOTE: the flit storage is deliberately not reset; count and pointers
    // alone decide which entries are live, and skipping the reset lets the
    // array map onto plain RAM/register-file cells.
    always_ff @(posedge clk) begin
        for (int p = 0; p < NP; p++) begin
            if (push[p]) fifo_mem[p][wr_ptr[p]] <= bus.in_flit[p*DATA_W +: DATA_W];
        end
    end

`ifdef ROUTER_STATS_EN
    // Delivered-flit counters; clear wins over a same-cycle delivery.
    logic [15:0] stat_q [NP];

    always_ff @(posedge clk) begin
        for (int o = 0; o < NP; o++) begin
            if (rst || stat_clr) begin
                stat_q[o] <= 16'd0;
            end else if (out_valid_q[o] && bus.out_ready[o] && (stat_q[o] != 16'hFFFF)) begin
                stat_q[o] <= stat_q[o] + 16'd1;
            end
        end
    end

    for (genvar g = 0; g < NP; g++) begin : g_stat
        assign stat_count[g*16 +: 16] = stat_q[g];
    end
`endif

endmodule

// File: tb/tb_mesh_router_xy.sv
// -----------------------------------------------------------------------------
// tb_mesh_router_xy
// Testbench for mesh_router_xy (DATA_W=16, COORD_W=4, FIFO_DEPTH=4,
// router at (3,3)). Build with ROUTER_STATS_EN defined to include the
// delivery-counter section.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_mesh_router_xy;

    localparam int DATA_W     = 16;
    localparam int COORD_W    = 4;
    localparam int FIFO_DEPTH = 4;
    localparam int NP         = 5;

    logic               clk = 1'b0;
    logic               rst;
    logic [COORD_W-1:0] my_x = 4'd3;
    logic [COORD_W-1:0] my_y = 4'd3;

    mesh_router_xy_if #(.DATA_W(DATA_W)) bus ();

`ifdef ROUTER_STATS_EN
    logic        stat_clr;
    logic [79:0] stat_count;
`endif

    mesh_router_xy #(
        .DATA_W     (DATA_W),
        .COORD_W    (COORD_W),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .my_x       (my_x),
        .my_y       (my_y),
        .bus        (bus)
`ifdef ROUTER_STATS_EN
        ,
        .stat_clr   (stat_clr),
        .stat_count (stat_count)
`endif
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    bit chk_en = 1'b0;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] expd);
        checks++;
        if (act !== expd) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, expd, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // ------------------------------------------------------------------
    // Reference model: queues per input, one slot per output, RR pointer.
    // ------------------------------------------------------------------
    logic [DATA_W-1:0] mq [NP][$];
    logic [NP-1:0]     m_ov;
    logic [DATA_W-1:0] m_of [NP];
    int                m_rr [NP];
`ifdef ROUTER_STATS_EN
    int                m_cnt [NP];
`endif

    function automatic int dest_port(input logic [DATA_W-1:0] f,
                                     input int mx, input int my);
        int dx;
        int dy;
        dx = int'(f[3:0]);
        dy = int'(f[7:4]);
        if (dx > mx) return 2;
        if (dx < mx) return 4;
        if (dy > my) return 1;
        if (dy < my) return 3;
        return 0;
    endfunction

    always @(posedge clk) begin : model
        int            gnt [NP];
        logic [NP-1:0] acc;
        int            idx;
        if (rst) begin
            for (int p = 0; p < NP; p++) begin
                mq[p].delete();
                m_of[p] = '0;
                m_rr[p] = 0;
`ifdef ROUTER_STATS_EN
                m_cnt[p] = 0;
`endif
            end
            m_ov = '0;
        end else begin
            for (int p = 0; p < NP; p++)
                acc[p] = bus.in_valid[p] && (mq[p].size() < FIFO_DEPTH);
            for (int o = 0; o < NP; o++) begin
`ifdef ROUTER_STATS_EN
                if (stat_clr) m_cnt[o] = 0;
                else if (m_ov[o] && bus.out_ready[o] && m_cnt[o] < 65535) m_cnt[o]++;
`endif
                gnt[o] = -1;
                if (!m_ov[o] || bus.out_ready[o]) begin
                    for (int k = 0; k < NP; k++) begin
                        idx = (m_rr[o] + k) % NP;
                        if (gnt[o] < 0 && mq[idx].size() != 0 &&
                            dest_port(mq[idx][0], int'(my_x), int'(my_y)) == o)
                            gnt[o] = idx;
                    end
                end
            end
            for (int o = 0; o < NP; o++) begin
                if (gnt[o] >= 0) begin
                    m_of[o] = mq[gnt[o]][0];
                    m_ov[o] = 1'b1;
                    m_rr[o] = (gnt[o] + 1) % NP;
                end else if (bus.out_ready[o]) begin
                    m_ov[o] = 1'b0;
                end
            end
            for (int o = 0; o < NP; o++)
                if (gnt[o] >= 0) void'(mq[gnt[o]].pop_front());
            for (int p = 0; p < NP; p++)
                if (acc[p]) mq[p].push_back(bus.in_flit[p*DATA_W +: DATA_W]);
        end
    end

    // Compare process: every cycle once reset has been applied.
    always @(negedge clk) begin : compare
        logic [NP-1:0] exp_ready;
        if (chk_en) begin
            for (int p = 0; p < NP; p++)
                exp_ready[p] = !rst && (mq[p].size() < FIFO_DEPTH);
            check("in_ready", bus.in_ready, exp_ready);
            check("out_valid", bus.out_valid, m_ov);
            for (int o = 0; o < NP; o++)
                if (m_ov[o])
                    check($sformatf("out_flit[%0d]", o), bus.out_flit[o*DATA_W +: DATA_W], m_of[o]);
`ifdef ROUTER_STATS_EN
            for (int o = 0; o < NP; o++)
                check($sformatf("stat_count[%0d]", o), stat_count[o*16 +: 16], 128'(m_cnt[o]));
`endif
        end
    end

    // Watchdog
    initial begin
        #1_500_000;
        $display("FAIL watchdog: simulation time limit reached, expected $finish earlier");
        $fatal(1, "watchdog expired");
    end

    // ------------------------------------------------------------------
    // Directed and random stimulus
    // ------------------------------------------------------------------
    int          exp_port [5] = '{2, 4, 1, 3, 0};
    logic [3:0]  dec_x    [5] = '{4'd5, 4'd1, 4'd3, 4'd3, 4'd3};
    logic [3:0]  dec_y    [5] = '{4'd1, 4'd3, 4'd6, 4'd0, 4'd3};
    logic [15:0] bp_flit  [6];
    logic [15:0] f, f_n, f_e, f_w, e0, s0, n0;
    int          k;
    bit          acc4;

    initial begin
        rst           = 1'b1;
        bus.in_valid  = '0;
        bus.in_flit   = '0;
        bus.out_ready = 5'h1F;
`ifdef ROUTER_STATS_EN
        stat_clr      = 1'b0;
`endif
        repeat (2) @(posedge clk);
        #1 chk_en = 1'b1;

        // Reset values
        @(negedge clk);
        check("rst_in_ready", bus.in_ready, 5'h00);
        check("rst_out_valid", bus.out_valid, 5'h00);
        check("rst_out_flit", bus.out_flit, 80'h0);
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("post_rst_in_ready", bus.in_ready, 5'h1F);

        // Route decode from Local, 2-cycle latency, payload preserved
        tick();
        for (int i = 0; i < 5; i++) begin
            f = {8'(8'hA0 + i), dec_y[i], dec_x[i]};
            bus.in_flit[0 +: DATA_W] = f;
            bus.in_valid = 5'b00001;
            tick();
            bus.in_valid = '0;
            @(negedge clk);
            check("decode_not_early", bus.out_valid, 5'h00);
            tick();
            @(negedge clk);
            check("decode_valid", bus.out_valid, 5'(5'b1 << exp_port[i]));
            check("decode_flit", bus.out_flit[exp_port[i]*DATA_W +: DATA_W], f);
            tick();
        end

        // Round-robin into Local from North, East, West
        f_n = {8'hB1, 4'd3, 4'd3};
        f_e = {8'hB2, 4'd3, 4'd3};
        f_w = {8'hB4, 4'd3, 4'd3};
        bus.in_flit[1*DATA_W +: DATA_W] = f_n;
        bus.in_flit[2*DATA_W +: DATA_W] = f_e;
        bus.in_flit[4*DATA_W +: DATA_W] = f_w;
        bus.in_valid = 5'b10110;
        tick();
        bus.in_valid = '0;
        tick();
        @(negedge clk);
        check("rr_first", bus.out_flit[0 +: DATA_W], f_n);
        tick();
        @(negedge clk);
        check("rr_second", bus.out_flit[0 +: DATA_W], f_e);
        tick();
        @(negedge clk);
        check("rr_third", bus.out_flit[0 +: DATA_W], f_w);
        check("rr_third_valid", bus.out_valid, 5'b00001);
        check("rr_ptr_local", dut.rr_ptr[0], 3'd0);
        tick();
        tick();

        // Backpressure on East, West fills its FIFO
        for (int i = 0; i < 6; i++) bp_flit[i] = {8'(8'hD0 + i), 4'd3, 4'd7};
        bus.out_ready = 5'b11011;
        k = 0;
        for (int c = 0; c < 10; c++) begin
            bus.in_valid = (k < 6) ? 5'b10000 : 5'b00000;
            bus.in_flit[4*DATA_W +: DATA_W] = bp_flit[k];
            @(negedge clk);
            acc4 = bus.in_valid[4] && bus.in_ready[4];
            tick();
            if (acc4) k++;
        end
        @(negedge clk);
        check("bp_accepted", 128'(k), 128'd5);
        check("bp_in_ready_w", bus.in_ready[4], 1'b0);
        check("bp_held_valid", bus.out_valid[2], 1'b1);
        check("bp_held_flit", bus.out_flit[2*DATA_W +: DATA_W], bp_flit[0]);
        tick();
        bus.in_valid  = '0;
        bus.out_ready = 5'h1F;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("bp_drain_valid", bus.out_valid[2], 1'b1);
            check("bp_drain_flit", bus.out_flit[2*DATA_W +: DATA_W], bp_flit[i]);
            tick();
        end
        @(negedge clk);
        check("bp_drain_done", bus.out_valid[2], 1'b0);
        tick();

        // Head-of-line isolation: South stalls behind blocked East, Local->North proceeds
        e0 = {8'hC0, 4'd3, 4'd7};
        s0 = {8'hC3, 4'd3, 4'd7};
        n0 = {8'hC1, 4'd5, 4'd3};
        bus.out_ready = 5'b11011;
        bus.in_flit[0 +: DATA_W] = e0;
        bus.in_valid = 5'b00001;
        tick();
        bus.in_valid = '0;
        tick();
        bus.in_flit[0 +: DATA_W]        = n0;
        bus.in_flit[3*DATA_W +: DATA_W] = s0;
        bus.in_valid = 5'b01001;
        tick();
        bus.in_valid = '0;
        tick();
        @(negedge clk);
        check("hol_valid", bus.out_valid, 5'b00110);
        check("hol_north_flit", bus.out_flit[1*DATA_W +: DATA_W], n0);
        check("hol_east_flit", bus.out_flit[2*DATA_W +: DATA_W], e0);
        repeat (3) tick();
        @(negedge clk);
        check("hol_stalled_valid", bus.out_valid, 5'b00100);
        check("hol_stalled_flit", bus.out_flit[2*DATA_W +: DATA_W], e0);
        tick();
        bus.out_ready = 5'h1F;
        tick();
        @(negedge clk);
        check("hol_release_flit", bus.out_flit[2*DATA_W +: DATA_W], s0);
        tick();
        tick();

        // Reset mid-flight with three flits inside
        bus.out_ready = '0;
        bus.in_flit[0 +: DATA_W]        = {8'hE0, 4'd3, 4'd9};
        bus.in_flit[1*DATA_W +: DATA_W] = {8'hE1, 4'd3, 4'd9};
        bus.in_flit[3*DATA_W +: DATA_W] = {8'hE3, 4'd3, 4'd9};
        bus.in_valid = 5'b01011;
        tick();
        bus.in_valid = '0;
        tick();
        rst = 1'b1;
        @(negedge clk);
        check("mid_rst_in_ready", bus.in_ready, 5'h00);
        check("mid_rst_pre_valid", bus.out_valid, 5'b00100);
        tick();
        rst = 1'b0;
        bus.out_ready = 5'h1F;
        @(negedge clk);
        check("mid_rst_out_valid", bus.out_valid, 5'h00);
        check("mid_rst_in_ready_back", bus.in_ready, 5'h1F);
        for (int i = 0; i < 4; i++) begin
            tick();
            @(negedge clk);
            check("mid_rst_no_stale", bus.out_valid, 5'h00);
        end
        tick();

        // Randomized traffic against the model
        for (int c = 0; c < 3000; c++) begin
            for (int p = 0; p < NP; p++)
                bus.in_flit[p*DATA_W +: DATA_W] =
                    {8'($urandom), 4'($urandom_range(0, 7)), 4'($urandom_range(0, 7))};
            bus.in_valid  = 5'($urandom);
            bus.out_ready = 5'($urandom) | 5'($urandom);
            rst           = ($urandom_range(0, 499) == 0);
`ifdef ROUTER_STATS_EN
            stat_clr      = ($urandom_range(0, 199) == 0);
`endif
            tick();
        end
        rst           = 1'b0;
        bus.in_valid  = '0;
        bus.out_ready = 5'h1F;
`ifdef ROUTER_STATS_EN
        stat_clr      = 1'b0;
`endif
        repeat (10) tick();

`ifdef ROUTER_STATS_EN
        // Saturation on East, then clear colliding with a delivery
        stat_clr = 1'b1;
        tick();
        stat_clr = 1'b0;
        bus.in_flit[0 +: DATA_W] = {8'h5A, 4'd3, 4'd5};
        bus.in_valid = 5'b00001;
        repeat (70010) tick();
        @(negedge clk);
        check("stat_saturated", stat_count[2*16 +: 16], 16'hFFFF);
        check("stat_deliver_pending", bus.out_valid[2], 1'b1);
        tick();
        stat_clr = 1'b1;
        tick();
        stat_clr = 1'b0;
        @(negedge clk);
        check("stat_clr_wins", stat_count[2*16 +: 16], 16'h0000);
        tick();
        bus.in_valid = '0;
        repeat (4) tick();
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
